bit_axi_arbiter: RTL and testbench
==================================

# bit_axi_arbiter

Single-master AXI scheduler for the CPU core. It accepts SRAM-like requests from the instruction-fetch port and the data (load/store) port and grants one of them at a time. It drives each granted request as one single-beat AXI read or write, and returns the completion to the owning requester. It sits between the pipeline's fetch/memory stages and the SoC AXI crossbar, and owns all AR/R/AW/W/B channel sequencing.

## Interface

Parameters:
- none

Ports (one transaction outstanding, 32-bit data bus):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch request; held by requester until inst_addr_ok
- inst_addr  in  32  fetch address (word read, size 3'b010)
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  one-cycle completion pulse
- inst_rdata  out  32  read data, valid with inst_data_ok, held until next completion
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_size  in  3  AXI size (0/1/2)
- data_addr  in  32  byte address
- data_wstrb  in  4  byte strobes (writes)
- data_wdata  in  32  write data
- data_addr_ok, data_data_ok  out  1 each  as for inst port
- data_rdata  out  32  as inst_rdata
- bus_err  out  1  one-cycle pulse with any data_ok whose rresp/bresp != 2'b00
- arid[3:0], araddr[32], arsize[3], arvalid  out; arready  in
- rid[4], rdata[32], rresp[2], rlast, rvalid  in; rready  out
- awaddr[32], awsize[3], awvalid  out; awready  in
- wdata[32], wstrb[4], wlast, wvalid  out; wready  in
- bid[4], bresp[2], bvalid  in; bready  out
- Tie-offs: arlen = awlen = 0, arburst = awburst = 2'b01, lock/cache/prot = 0, awid = wid = 4'd1, wlast = 1

## Operation

- States: IDLE, AR, R, AW_W, B.
- IDLE: if any req is high, grant one. The granted port's addr_ok is asserted combinationally this cycle. Addr/size/wr/wstrb/wdata and the owner are latched. Next state is AW_W if the request is a data write, else AR.
- AR: arvalid = 1 with the latched addr/size. arid = 0 for inst, 1 for data. On arvalid & arready -> R.
- R: rready = 1. On rvalid: capture rdata and rresp, register the owner's data_ok pulse for the next cycle, -> IDLE. rid and rlast are not checked.
- AW_W: awvalid and wvalid rise together. Each drops independently after its own handshake. When both handshakes are complete (same or different cycles) -> B.
- B: bready = 1. On bvalid: register data_ok and bresp check, -> IDLE. rdata outputs are unchanged on writes.
- Requests arriving outside IDLE get no addr_ok and must be held by the requester.
- A write with data_wstrb = 0 is still issued on the bus.
- Arbitration default is fixed priority: data over inst.

## Timing

- Reset values: all valid/ready outputs 0, all addr_ok/data_ok 0, bus_err 0, inst_rdata = data_rdata = 0, state IDLE, round-robin pointer = inst.
- Read latency: req granted in cycle N; arvalid in N+1; with arready at N+1 and rvalid at N+2, data_ok is asserted in N+3. The block is back in IDLE in N+3 and can grant again in N+3.
- Write latency: grant in N; aw/w valid in N+1; with both readys at N+1 and bvalid at N+2, data_ok is asserted in N+3.
- Valids hold stable until handshake. Address/data do not change while valid is high.
- Simultaneous inst_req and data_req in IDLE: only the winner gets addr_ok. The loser waits at least until the next IDLE.
- Reset mid-transaction: immediate return to IDLE with all valids dropped. No data_ok is issued. Permitted only at system reset.

## Configuration

- ARB_ROUND_ROBIN_EN: when defined, a 1-bit pointer records the last-served port. On a simultaneous request the other port wins. The pointer updates on each grant. When undefined, data always wins and the pointer logic is absent.

## Test plan

- Inst read 0xBFC00000, arready immediate, rvalid next cycle with rdata 0x3C1DBFC0 -> inst_addr_ok at N, inst_data_ok at N+3, inst_rdata = 0x3C1DBFC0, arid = 0.
- Data write addr 0x80001000, wstrb 4'b0011, wdata 0x12345678; awready at N+1, wready delayed to N+3, bvalid at N+4 -> wvalid held until N+3, awvalid drops after N+1, data_data_ok at N+5.
- inst_req and data_req both high in IDLE, three back-to-back read pairs -> without the macro data is granted every time before inst. With ARB_ROUND_ROBIN_EN, grants alternate data, inst, data, inst.
- Read with rresp = 2'b10 -> data_data_ok and bus_err pulse together in the same cycle; the state returns to IDLE.
- rst asserted while in AR with arvalid = 1 -> arvalid = 0 the next cycle, no data_ok, state IDLE; a subsequent inst read completes normally.

Source files
------------

// File: rtl/bit_axi_arbiter.sv
// ---------------------------------------------------------------------------
// bit_axi_arbiter
//
// Arbitrates between the CPU instruction-fetch port and the data
// (load/store) port. Each granted request becomes one single-beat AXI read
// or write. Only one transaction is outstanding at a time. The completion
// is returned to the port that owns the transaction.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN - when two requests arrive together, the port that
//                        was not served last wins. When the macro is not
//                        defined, the data port always wins.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   inst_*              fetch port (word reads only)
//   data_*              load/store port (reads and writes, size 0/1/2)
//   bus_err             pulses together with a data_ok whose AXI response
//                       was not OKAY
//   ar*/r*/aw*/w*/b*    AXI master channels. len/burst/lock/cache/prot and
//                       awid/wid/wlast are fixed.
//
// States:
//   state | meaning
//   IDLE  | no transaction; a pending request is granted this cycle
//   AR    | read address valid, waiting for arready
//   R     | waiting for the read data beat
//   AW_W  | write address and write data valid, each waiting for its ready
//   B     | waiting for the write response
// ---------------------------------------------------------------------------
module bit_axi_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_err,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_owner;        // 0 = inst, 1 = data
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;

    logic        r_inst_data_ok;
    logic        r_data_data_ok;
    logic        r_bus_err;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    logic        w_pick_data;
    logic        w_grant_inst;
    logic        w_grant_data;
    logic        w_r_done;
    logic        w_b_done;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_awvalid;
    logic        w_wvalid;
    logic        w_bready;

    // Read ID, read last and write ID are not checked.
    logic        w_unused_ok;
    assign w_unused_ok = ^{rid, rlast, bid};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_data;           // 1 = data port was served last

    // The data port wins when only data is requesting. It also wins
    // when inst was served last.
    assign w_pick_data = data_req && (!inst_req || !r_last_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_data <= 1'b0;
        end else if (w_grant_data) begin
            r_last_data <= 1'b1;
        end else if (w_grant_inst) begin
            r_last_data <= 1'b0;
        end
    end
`else
    assign w_pick_data = data_req;
`endif

    assign w_grant_data = (r_state == S_IDLE) && w_pick_data;
    assign w_grant_inst = (r_state == S_IDLE) && inst_req && !w_pick_data;

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_data && data_wr) begin
                    w_next = S_AW_W;
                end else if (w_grant_data || w_grant_inst) begin
                    w_next = S_AR;
                end
            end
            S_AR: begin
                w_arvalid = 1'b1;
                if (arready) begin
                    w_next = S_R;
                end
            end
            S_R: begin
                w_rready = 1'b1;
                if (rvalid) begin
                    w_next = S_IDLE;
                end
            end
            S_AW_W: begin
                // Each channel drops its valid after its own handshake.
                // Move on once both handshakes have happened.
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || awready) && (r_w_done || wready)) begin
                    w_next = S_B;
                end
            end
            S_B: begin
                w_bready = 1'b1;
                if (bvalid) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and write-handshake tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_addr  <= 32'd0;
            r_size  <= 3'd0;
            r_wstrb <= 4'd0;
            r_wdata <= 32'd0;
        end else if (w_grant_data) begin
            r_owner <= 1'b1;
            r_addr  <= data_addr;
            r_size  <= data_size;
            r_wstrb <= data_wstrb;
            r_wdata <= data_wdata;
        end else if (w_grant_inst) begin
            r_owner <= 1'b0;
            r_addr  <= inst_addr;
            r_size  <= 3'b010;
            r_wstrb <= 4'd0;
            r_wdata <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_AW_W)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_awvalid && awready) begin
                r_aw_done <= 1'b1;
            end
            if (w_wvalid && wready) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion
    // ------------------------------------------------------------------
    assign w_r_done = (r_state == S_R) && rvalid;
    assign w_b_done = (r_state == S_B) && bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            r_bus_err      <= 1'b0;
            r_inst_rdata   <= 32'd0;
            r_data_rdata   <= 32'd0;
        end else begin
            r_inst_data_ok <= (w_r_done || w_b_done) && !r_owner;
            r_data_data_ok <= (w_r_done || w_b_done) && r_owner;
            r_bus_err      <= (w_r_done && (rresp != 2'b00)) ||
                              (w_b_done && (bresp != 2'b00));
            if (w_r_done && !r_owner) begin
                r_inst_rdata <= rdata;
            end
            if (w_r_done && r_owner) begin
                r_data_rdata <= rdata;
            end
        end
    end

    assign inst_data_ok = r_inst_data_ok;
    assign data_data_ok = r_data_data_ok;
    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;
    assign bus_err      = r_bus_err;

    // ------------------------------------------------------------------
    // AXI channel outputs
    // ------------------------------------------------------------------
    assign arid    = {3'b000, r_owner};
    assign araddr  = r_addr;
    assign arsize  = r_size;
    assign arvalid = w_arvalid;
    assign rready  = w_rready;

    assign awid    = 4'd1;
    assign awaddr  = r_addr;
    assign awsize  = r_size;
    assign awvalid = w_awvalid;

    assign wid     = 4'd1;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = w_wvalid;

    assign bready  = w_bready;

    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

endmodule

// File: tb/tb_bit_axi_arbiter.sv
module tb_bit_axi_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    bit_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        logic [1:0]  resp;
        logic [2:0]  exp_axsize;
        logic [3:0]  exp_id;
        logic        exp_err;
        logic [31:0] exp_inst_rdata;
        logic [31:0] exp_data_rdata;
    } vec_t;

    vec_t vecs[6];

    // One transaction with zero-wait AXI responses. Grant happens in cycle N
    // and the completion pulse appears in N+3.
    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        if (v.is_data) begin
            data_req   = 1'b1;
            data_wr    = v.wr;
            data_size  = v.size;
            data_addr  = v.addr;
            data_wstrb = v.wstrb;
            data_wdata = v.wdata;
        end else begin
            inst_req  = 1'b1;
            inst_addr = v.addr;
        end
        @(negedge clk);
        chk("addr_ok", v.is_data ? data_addr_ok : inst_addr_ok, 32'd1);
        chk("other_addr_ok", v.is_data ? inst_addr_ok : data_addr_ok, 32'd0);
        @(posedge clk); #1;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        inst_addr  = 32'hFFFF_FFFF;
        data_addr  = 32'hFFFF_FFFF;
        data_wdata = ~v.wdata;
        data_wstrb = ~v.wstrb;
        if (!v.wr) begin
            arready = 1'b1;
            @(negedge clk);
            chk("arvalid", arvalid, 32'd1);
            chk("araddr", araddr, v.addr);
            chk("arsize", arsize, v.exp_axsize);
            chk("arid", arid, v.exp_id);
            @(posedge clk); #1;
            arready = 1'b0;
            rvalid  = 1'b1;
            rdata   = v.bus_rdata;
            rresp   = v.resp;
            rid     = v.exp_id;
            rlast   = 1'b1;
            @(negedge clk);
            chk("rready", rready, 32'd1);
            chk("arvalid_drop", arvalid, 32'd0);
            @(posedge clk); #1;
            rvalid = 1'b0;
            rdata  = 32'h0BAD_0BAD;
        end else begin
            awready = 1'b1;
            wready  = 1'b1;
            @(negedge clk);
            chk("awvalid", awvalid, 32'd1);
            chk("wvalid", wvalid, 32'd1);
            chk("awaddr", awaddr, v.addr);
            chk("awsize", awsize, v.exp_axsize);
            chk("awid", awid, v.exp_id);
            chk("wdata", wdata, v.wdata);
            chk("wstrb", wstrb, v.wstrb);
            chk("wlast", wlast, 32'd1);
            @(posedge clk); #1;
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b1;
            bresp   = v.resp;
            bid     = 4'd1;
            @(negedge clk);
            chk("bready", bready, 32'd1);
            chk("awvalid_drop", awvalid, 32'd0);
            chk("wvalid_drop", wvalid, 32'd0);
            @(posedge clk); #1;
            bvalid = 1'b0;
        end
        @(negedge clk);
        chk("data_ok", v.is_data ? data_data_ok : inst_data_ok, 32'd1);
        chk("other_data_ok", v.is_data ? inst_data_ok : data_data_ok, 32'd0);
        chk("bus_err", bus_err, {31'd0, v.exp_err});
        chk("inst_rdata", inst_rdata, v.exp_inst_rdata);
        chk("data_rdata", data_rdata, v.exp_data_rdata);
        @(posedge clk); #1;
        @(negedge clk);
        chk("data_ok_pulse", v.is_data ? data_data_ok : inst_data_ok, 32'd0);
        chk("bus_err_pulse", bus_err, 32'd0);
    endtask

    // Entered at N+1 (just after the grant edge). Returns just after the
    // N+3 edge, before the completion is sampled.
    task automatic serve_read(input logic [3:0] id, input logic [31:0] val);
        arready = 1'b1;
        @(negedge clk);
        chk("arb_arvalid", arvalid, 32'd1);
        chk("arb_arid", arid, id);
        @(posedge clk); #1;
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = val;
        rresp   = 2'b00;
        @(negedge clk);
        chk("arb_rready", rready, 32'd1);
        @(posedge clk); #1;
        rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic exp_data_win[6];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 3'd2, 32'hBFC0_0000, 4'h0, 32'h0, 32'h3C1D_BFC0, 2'b00,
                    3'd2, 4'd0, 1'b0, 32'h3C1D_BFC0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 3'd0, 32'h8000_0003, 4'h0, 32'h0, 32'h0000_00AB, 2'b00,
                    3'd0, 4'd1, 1'b0, 32'h3C1D_BFC0, 32'h0000_00AB};
        vecs[2] = '{1'b1, 1'b1, 3'd2, 32'h8000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0, 2'b00,
                    3'd2, 4'd1, 1'b0, 32'h3C1D_BFC0, 32'h0000_00AB};
        vecs[3] = '{1'b1, 1'b0, 3'd1, 32'h8000_0010, 4'h0, 32'h0, 32'h5555_AAAA, 2'b10,
                    3'd1, 4'd1, 1'b1, 32'h3C1D_BFC0, 32'h5555_AAAA};
        vecs[4] = '{1'b1, 1'b1, 3'd2, 32'h8000_2000, 4'h0, 32'h0, 32'h0, 2'b11,
                    3'd2, 4'd1, 1'b1, 32'h3C1D_BFC0, 32'h5555_AAAA};
        vecs[5] = '{1'b0, 1'b0, 3'd2, 32'hBFC0_0004, 4'h0, 32'h0, 32'h0000_0000, 2'b00,
                    3'd2, 4'd0, 1'b0, 32'h0000_0000, 32'h5555_AAAA};

        exp_data_win = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 3'd0; data_addr = 32'd0;
        data_wstrb = 4'd0; data_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'b00; bvalid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", arvalid, 32'd0);
        chk("rst_rready", rready, 32'd0);
        chk("rst_awvalid", awvalid, 32'd0);
        chk("rst_wvalid", wvalid, 32'd0);
        chk("rst_bready", bready, 32'd0);
        chk("rst_inst_data_ok", inst_data_ok, 32'd0);
        chk("rst_data_data_ok", data_data_ok, 32'd0);
        chk("rst_bus_err", bus_err, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("tie_arburst", {30'd0, arburst}, 32'd1);
        chk("tie_awlen", {28'd0, awlen}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Write with awready at N+1, wready delayed to N+3, bvalid at N+4
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b1; data_size = 3'd2; data_addr = 32'h8000_1000;
        data_wstrb = 4'b0011; data_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("wr_addr_ok", data_addr_ok, 32'd1);
        @(posedge clk); #1;
        data_req = 1'b0; data_wdata = 32'd0; data_wstrb = 4'd0;
        awready = 1'b1; wready = 1'b0;
        @(negedge clk);
        chk("wr_n1_awvalid", awvalid, 32'd1);
        chk("wr_n1_wvalid", wvalid, 32'd1);
        @(posedge clk); #1;
        awready = 1'b0;
        @(negedge clk);
        chk("wr_n2_awvalid", awvalid, 32'd0);
        chk("wr_n2_wvalid", wvalid, 32'd1);
        chk("wr_n2_wdata", wdata, 32'h1234_5678);
        chk("wr_n2_wstrb", wstrb, 32'h3);
        @(posedge clk); #1;
        wready = 1'b1;
        @(negedge clk);
        chk("wr_n3_wvalid", wvalid, 32'd1);
        chk("wr_n3_bready", bready, 32'd0);
        @(posedge clk); #1;
        wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        chk("wr_n4_wvalid", wvalid, 32'd0);
        chk("wr_n4_bready", bready, 32'd1);
        chk("wr_n4_data_ok", data_data_ok, 32'd0);
        @(posedge clk); #1;
        bvalid = 1'b0;
        @(negedge clk);
        chk("wr_n5_data_ok", data_data_ok, 32'd1);
        chk("wr_n5_bus_err", bus_err, 32'd0);

        // Simultaneous requests, three back-to-back read pairs
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_wr = 1'b0; data_size = 3'd2; data_addr = 32'h8000_3000;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            if (g > 0) begin
                chk("arb_prev_data_ok", exp_data_win[g-1] ? data_data_ok : inst_data_ok, 32'd1);
            end
            chk("arb_winner_ok", exp_data_win[g] ? data_addr_ok : inst_addr_ok, 32'd1);
            chk("arb_loser_ok", exp_data_win[g] ? inst_addr_ok : data_addr_ok, 32'd0);
            @(posedge clk); #1;
            if (exp_data_win[g]) data_req = 1'b0;
            else                 inst_req = 1'b0;
            serve_read(exp_data_win[g] ? 4'd1 : 4'd0, 32'h100 + g);
            if ((g < 5) && !inst_req && !data_req) begin
                inst_req = 1'b1;
                data_req = 1'b1;
            end
        end
        @(negedge clk);
        chk("arb_last_data_ok", inst_data_ok, 32'd1);
        chk("arb_inst_rdata", inst_rdata, 32'h105);
        chk("arb_data_rdata", data_rdata, 32'h104);

        // Reset while in AR with arvalid high
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
        @(negedge clk);
        chk("rstar_addr_ok", inst_addr_ok, 32'd1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        @(negedge clk);
        chk("rstar_arvalid_before", arvalid, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstar_arvalid_after", arvalid, 32'd0);
        chk("rstar_inst_data_ok", inst_data_ok, 32'd0);
        chk("rstar_inst_rdata", inst_rdata, 32'd0);
        chk("rstar_data_rdata", data_rdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rstar_idle_arvalid", arvalid, 32'd0);
            chk("rstar_idle_data_ok", {31'd0, inst_data_ok | data_data_ok}, 32'd0);
        end
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
